control_movimiento: RTL and testbench
=====================================

CONTROL_MOVIMIENTO -- requirements
Module: control_movimiento

Interface
REQ-001 Parameter PERIODO, default 25_000_000, number of clk cycles between snake steps; legal range 2 .. 2^25-1.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 boton_pres  input  3  button code from manejo_entradas: 0 none, 1 up, 2 down, 3 left, 4 right, 5 pause, 6-7 unused; a held level, not a pulse.
REQ-005 direccion  output  2  committed heading: 0 up, 1 down, 2 left, 3 right; registered.
REQ-006 estado  output  2  0 ESPERA, 1 CORRIENDO, 2 PAUSADO; registered.
REQ-007 pausado  output  1  high when estado == PAUSADO; registered.
REQ-008 paso  output  1  one-cycle move strobe to the game core; registered.

Function
REQ-009 The block SHALL register boton_pres into boton_prev every cycle; an event SHALL exist in a cycle when boton_pres != boton_prev, and it is acted on in that same cycle.
REQ-010 Event codes 0, 6, 7 SHALL be ignored; a code held unchanged SHALL generate no further events.
REQ-011 Direction request mapping: code 1->0, 2->1, 3->2, 4->3.
REQ-012 A request is legal only if it is not the opposite of the committed direccion (up/down, left/right); an illegal or equal request SHALL be dropped with no state change.
REQ-013 A legal request SHALL be stored in dir_pend; direccion SHALL load dir_pend only on the edge that sets paso, so at most one heading change takes effect per step.
REQ-014 Opposite-check SHALL use committed direccion, not dir_pend (a second request in one step overwrites dir_pend if legal against direccion).
REQ-015 If a legal request and a step commit occur in the same cycle, direccion and dir_pend SHALL both take the new request.
REQ-016 FSM ESPERA: direction event (legal against direccion) SHALL go to CORRIENDO, load dir_pend and direccion immediately, clear counter; pause event ignored.
REQ-017 FSM CORRIENDO: pause event SHALL go to PAUSADO; direction events handled per REQ-012..015.
REQ-018 FSM PAUSADO: pause event SHALL return to CORRIENDO; direction events SHALL be ignored (dir_pend unchanged).
REQ-019 Counter cnt (25 bits) SHALL increment only in CORRIENDO, hold its value in PAUSADO, and be zero in ESPERA.
REQ-020 When cnt == PERIODO-1 in CORRIENDO with no pause event that cycle: cnt <= 0, paso <= 1, direccion <= dir_pend (or request per REQ-015); otherwise paso <= 0.
REQ-021 Pause event coinciding with cnt == PERIODO-1: pause wins, no paso, cnt holds; on resume the step fires on the first CORRIENDO cycle.
REQ-022 paso SHALL be high for exactly one cycle and never in ESPERA or PAUSADO; consecutive paso pulses SHALL be exactly PERIODO cycles apart during uninterrupted running.
REQ-023 First paso SHALL be asserted PERIODO cycles after the edge entering CORRIENDO from ESPERA.

Reset
REQ-024 While reset is high on a clock edge: estado=ESPERA, direccion=3 (right), dir_pend=3, pausado=0, paso=0, cnt=0, boton_prev=0; reset overrides every event.
REQ-025 Reset asserted mid-run SHALL take effect on the next edge, dropping any pending direction and in-flight step.
REQ-026 After reset, a boton_pres already nonzero SHALL be treated as an event on the first cycle out of reset.

Verification (PERIODO=4)
REQ-027 Reset, hold boton_pres=0 for 20 cycles -> estado=0, paso never high, direccion=3.
REQ-028 From ESPERA set boton_pres=1 -> next edge estado=1, direccion=0; paso high at cycles 4, 8, 12 after entry, each one cycle wide.
REQ-029 Running heading up, set boton_pres=2 -> dropped, direccion stays 0; then 3 -> direccion becomes 2 only on the next paso cycle.
REQ-030 Running, set boton_pres=5 at cnt=2 -> pausado=1, no paso for 10 cycles, code 4 ignored; change to 0 then 5 -> resume, paso after 1 more cycle (cnt continues 3).
REQ-031 Pause event in the cycle cnt==3 -> no paso, estado=2, cnt stays 3; resume -> paso on first running cycle.
REQ-032 Assert reset while running with dir_pend pending -> next edge all outputs at reset values, pending heading lost.

Source files
------------

// File: rtl/control_movimiento.sv
// control_movimiento: turns held button codes into a committed snake heading,
// a run/pause state and a periodic one-cycle move strobe (paso).
// Heading changes are buffered in dir_pend and only take effect on the step
// edge, so the snake can turn at most once per step and never reverses.
module control_movimiento #(
  parameter int PERIODO = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] boton_pres,
  output logic [1:0] direccion,
  output logic [1:0] estado,
  output logic       pausado,
  output logic       paso
);

  // FSM encodings (visible on the estado port)
  localparam logic [1:0] ST_ESPERA    = 2'd0;
  localparam logic [1:0] ST_CORRIENDO = 2'd1;
  localparam logic [1:0] ST_PAUSADO   = 2'd2;

  // Heading encodings (visible on the direccion port)
  localparam logic [1:0] DIR_ARRIBA = 2'd0;
  localparam logic [1:0] DIR_ABAJO  = 2'd1;
  localparam logic [1:0] DIR_IZQ    = 2'd2;
  localparam logic [1:0] DIR_DER    = 2'd3;

  // Button codes coming from the input handler
  localparam logic [2:0] BTN_ARRIBA = 3'd1;
  localparam logic [2:0] BTN_ABAJO  = 3'd2;
  localparam logic [2:0] BTN_IZQ    = 3'd3;
  localparam logic [2:0] BTN_DER    = 3'd4;
  localparam logic [2:0] BTN_PAUSA  = 3'd5;

  // Last count value of a step period
  localparam logic [24:0] CNT_ULTIMO = 25'(PERIODO - 1);

  // Reverse of a heading: up<->down and left<->right differ only in bit 0
  function automatic logic [1:0] opuesta(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

  // State and datapath flops
  logic [1:0]  estado_q,     estado_d;
  logic [1:0]  direccion_q,  direccion_d;
  logic [1:0]  dir_pend_q,   dir_pend_d;
  logic [24:0] cnt_q,        cnt_d;
  logic        paso_q,       paso_d;
  logic        pausado_q,    pausado_d;
  logic [2:0]  boton_prev_q, boton_prev_d;

  // Decoded button events for the current cycle
  logic        evento_s;
  logic        ev_dir_s;
  logic        ev_pausa_s;
  logic [1:0]  dir_req_s;
  logic        req_no_opuesta_s;
  logic        req_nueva_s;
  logic        fin_periodo_s;

  // Decode a change of the button level into direction / pause events
  always_comb begin
    evento_s   = (boton_pres != boton_prev_q);
    dir_req_s  = DIR_ARRIBA;
    ev_dir_s   = 1'b0;
    ev_pausa_s = 1'b0;
    case (boton_pres)
      BTN_ARRIBA: begin
        dir_req_s = DIR_ARRIBA;
        ev_dir_s  = evento_s;
      end
      BTN_ABAJO: begin
        dir_req_s = DIR_ABAJO;
        ev_dir_s  = evento_s;
      end
      BTN_IZQ: begin
        dir_req_s = DIR_IZQ;
        ev_dir_s  = evento_s;
      end
      BTN_DER: begin
        dir_req_s = DIR_DER;
        ev_dir_s  = evento_s;
      end
      BTN_PAUSA: begin
        ev_pausa_s = evento_s;
      end
      default: begin
        // 0 (none) and the unused codes 6/7 never produce an event
        dir_req_s  = DIR_ARRIBA;
        ev_dir_s   = 1'b0;
        ev_pausa_s = 1'b0;
      end
    endcase
    // Legality is always judged against the committed heading, never dir_pend
    req_no_opuesta_s = (dir_req_s != opuesta(direccion_q));
    req_nueva_s      = req_no_opuesta_s && (dir_req_s != direccion_q);
    fin_periodo_s    = (cnt_q == CNT_ULTIMO);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ST_ESPERA;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_ESPERA: begin
        if (ev_dir_s && req_no_opuesta_s) begin
          estado_d = ST_CORRIENDO;
        end else begin
          estado_d = ST_ESPERA;
        end
      end
      ST_CORRIENDO: begin
        if (ev_pausa_s) begin
          estado_d = ST_PAUSADO;
        end else begin
          estado_d = ST_CORRIENDO;
        end
      end
      ST_PAUSADO: begin
        if (ev_pausa_s) begin
          estado_d = ST_CORRIENDO;
        end else begin
          estado_d = ST_PAUSADO;
        end
      end
      default: begin
        estado_d = ST_ESPERA;
      end
    endcase
  end

  // Output / datapath next values: counter, step strobe and heading buffer
  always_comb begin
    direccion_d  = direccion_q;
    dir_pend_d   = dir_pend_q;
    cnt_d        = cnt_q;
    paso_d       = 1'b0;
    boton_prev_d = boton_pres;
    case (estado_q)
      ST_ESPERA: begin
        // The first heading is committed at once so the game starts moving
        // in the pressed direction; the counter restarts from zero.
        cnt_d = 25'd0;
        if (ev_dir_s && req_no_opuesta_s) begin
          dir_pend_d  = dir_req_s;
          direccion_d = dir_req_s;
        end else begin
          dir_pend_d  = dir_pend_q;
          direccion_d = direccion_q;
        end
      end
      ST_CORRIENDO: begin
        if (ev_pausa_s) begin
          // Pause wins over a coinciding step: the count is frozen so the
          // step fires on the first running cycle after resuming.
          cnt_d = cnt_q;
        end else if (fin_periodo_s) begin
          cnt_d  = 25'd0;
          paso_d = 1'b1;
          if (ev_dir_s && req_nueva_s) begin
            // A request arriving on the step edge is committed directly
            dir_pend_d  = dir_req_s;
            direccion_d = dir_req_s;
          end else begin
            dir_pend_d  = dir_pend_q;
            direccion_d = dir_pend_q;
          end
        end else begin
          cnt_d = cnt_q + 25'd1;
          if (ev_dir_s && req_nueva_s) begin
            dir_pend_d = dir_req_s;
          end else begin
            dir_pend_d = dir_pend_q;
          end
        end
      end
      ST_PAUSADO: begin
        // Everything holds; direction presses are ignored while paused
        cnt_d       = cnt_q;
        dir_pend_d  = dir_pend_q;
        direccion_d = direccion_q;
      end
      default: begin
        cnt_d       = 25'd0;
        dir_pend_d  = DIR_DER;
        direccion_d = DIR_DER;
      end
    endcase
    pausado_d = (estado_d == ST_PAUSADO);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      direccion_q  <= DIR_DER;
      dir_pend_q   <= DIR_DER;
      cnt_q        <= 25'd0;
      paso_q       <= 1'b0;
      pausado_q    <= 1'b0;
      boton_prev_q <= 3'd0;
    end else begin
      direccion_q  <= direccion_d;
      dir_pend_q   <= dir_pend_d;
      cnt_q        <= cnt_d;
      paso_q       <= paso_d;
      pausado_q    <= pausado_d;
      boton_prev_q <= boton_prev_d;
    end
  end

  assign direccion = direccion_q;
  assign estado    = estado_q;
  assign pausado   = pausado_q;
  assign paso      = paso_q;

endmodule

// File: tb/tb_control_movimiento.sv
// tb_control_movimiento: directed scenarios with a cycle-stamped scoreboard.
// The stimulus process pushes expected state snapshots and expected paso
// pulses (cycle + heading); a monitor on the falling edge pops and compares.
module tb_control_movimiento;

  localparam int P       = 4;
  localparam int END_CYC = 92;

  logic       clk;
  logic       reset;
  logic [2:0] boton_pres;
  logic [1:0] direccion;
  logic [1:0] estado;
  logic       pausado;
  logic       paso;

  control_movimiento #(.PERIODO(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .boton_pres (boton_pres),
    .direccion  (direccion),
    .estado     (estado),
    .pausado    (pausado),
    .paso       (paso)
  );

  typedef struct {
    int         cyc;
    logic [1:0] est;
    logic [1:0] dir;
    logic       pau;
  } st_exp_t;

  typedef struct {
    int         cyc;
    logic [1:0] dir;
  } paso_exp_t;

  st_exp_t   st_q[$];
  paso_exp_t paso_q[$];
  st_exp_t   mon_s;
  paso_exp_t mon_p;

  int cyc;
  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rising-edge counter: at the falling edge after edge k, cyc == k
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_st(input int c, input logic [1:0] e,
                                  input logic [1:0] d, input logic p);
    st_exp_t s;
    s.cyc = c;
    s.est = e;
    s.dir = d;
    s.pau = p;
    st_q.push_back(s);
  endfunction

  function automatic void push_paso(input int c, input logic [1:0] d);
    paso_exp_t x;
    x.cyc = c;
    x.dir = d;
    paso_q.push_back(x);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Stimulus: drives inputs on the falling edge and pushes expectations
  initial begin
    reset      = 1'b1;
    boton_pres = 3'd0;
    push_st(2, 2'd0, 2'd3, 1'b0);            // values while in reset
    push_st(22, 2'd0, 2'd3, 1'b0);           // idle 20 cycles, no paso
    wait_until(2);
    reset = 1'b0;

    wait_until(22);
    boton_pres = 3'd5;                        // pause in ESPERA ignored
    push_st(23, 2'd0, 2'd3, 1'b0);
    wait_until(23);
    boton_pres = 3'd1;                        // up: start running, entry edge 24
    push_st(24, 2'd1, 2'd0, 1'b0);
    push_paso(28, 2'd0);
    push_paso(32, 2'd0);
    push_paso(36, 2'd0);

    wait_until(37);
    boton_pres = 3'd2;                        // down while up: dropped
    push_st(38, 2'd1, 2'd0, 1'b0);
    wait_until(38);
    boton_pres = 3'd3;                        // left: pending until paso
    push_st(39, 2'd1, 2'd0, 1'b0);
    push_st(40, 2'd1, 2'd2, 1'b0);
    push_paso(40, 2'd2);
    push_paso(44, 2'd2);

    wait_until(46);
    boton_pres = 3'd5;                        // pause with cnt == 2
    push_st(47, 2'd2, 2'd2, 1'b1);
    wait_until(49);
    boton_pres = 3'd4;                        // ignored while paused
    wait_until(51);
    boton_pres = 3'd1;                        // would be legal, still ignored
    wait_until(54);
    boton_pres = 3'd0;
    push_st(57, 2'd2, 2'd2, 1'b1);
    wait_until(57);
    boton_pres = 3'd5;                        // resume: cnt 2 -> 3 -> paso
    push_st(58, 2'd1, 2'd2, 1'b0);
    push_paso(60, 2'd2);

    wait_until(61);
    boton_pres = 3'd0;
    wait_until(63);
    boton_pres = 3'd5;                        // pause in the cnt == 3 cycle
    push_st(64, 2'd2, 2'd2, 1'b1);
    wait_until(65);
    boton_pres = 3'd0;
    wait_until(67);
    boton_pres = 3'd5;                        // resume: paso on first run cycle
    push_st(68, 2'd1, 2'd2, 1'b0);
    push_paso(69, 2'd2);

    wait_until(72);
    boton_pres = 3'd1;                        // up arrives on the commit edge
    push_paso(73, 2'd0);
    wait_until(73);
    boton_pres = 3'd3;                        // left pending
    wait_until(74);
    boton_pres = 3'd4;                        // right: legal vs up, overwrites
    push_st(75, 2'd1, 2'd0, 1'b0);
    push_paso(77, 2'd3);

    wait_until(78);
    boton_pres = 3'd1;                        // up pending against right
    wait_until(79);
    reset      = 1'b1;                        // reset mid-run drops it all
    boton_pres = 3'd0;
    push_st(80, 2'd0, 2'd3, 1'b0);
    wait_until(80);
    reset = 1'b0;
    push_st(84, 2'd0, 2'd3, 1'b0);            // stays idle, step at 81 lost

    wait_until(84);
    reset      = 1'b1;
    boton_pres = 3'd1;                        // held through reset
    push_st(85, 2'd0, 2'd3, 1'b0);
    wait_until(85);
    reset = 1'b0;                             // seen as an event at edge 86
    push_st(86, 2'd1, 2'd0, 1'b0);
    push_paso(90, 2'd0);
  end

  // Monitor: compares state snapshots and paso pulses against the queues
  always @(negedge clk) begin
    while (st_q.size() > 0 && st_q[0].cyc < cyc) begin
      mon_s = st_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL state_missed: snapshot for cycle %0d skipped (now %0d)", mon_s.cyc, cyc);
    end
    if (st_q.size() > 0 && st_q[0].cyc == cyc) begin
      mon_s = st_q.pop_front();
      n_tests++;
      if (estado !== mon_s.est || direccion !== mon_s.dir || pausado !== mon_s.pau) begin
        n_fail++;
        $display("FAIL state@%0d: got estado=%0d direccion=%0d pausado=%0d, expected estado=%0d direccion=%0d pausado=%0d",
                 cyc, estado, direccion, pausado, mon_s.est, mon_s.dir, mon_s.pau);
      end
    end

    if (paso === 1'b1) begin
      n_tests++;
      if (paso_q.size() > 0 && paso_q[0].cyc == cyc) begin
        mon_p = paso_q.pop_front();
        if (direccion !== mon_p.dir) begin
          n_fail++;
          $display("FAIL paso_dir@%0d: got direccion=%0d, expected %0d", cyc, direccion, mon_p.dir);
        end
      end else begin
        n_fail++;
        $display("FAIL paso_unexpected@%0d: got paso=1, expected 0", cyc);
      end
    end else if (paso_q.size() > 0 && paso_q[0].cyc <= cyc) begin
      mon_p = paso_q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL paso_missed@%0d: got paso=%b, expected 1 at cycle %0d", cyc, paso, mon_p.cyc);
    end

    if (cyc == END_CYC) begin
      while (st_q.size() > 0) begin
        mon_s = st_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL state_unchecked: snapshot for cycle %0d never compared", mon_s.cyc);
      end
      while (paso_q.size() > 0) begin
        mon_p = paso_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL paso_unchecked: got none, expected paso at cycle %0d", mon_p.cyc);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  // Watchdog in case the run never reaches the final cycle
  initial begin
    n_tests = 0;
    n_fail  = 0;
    #5000;
    $display("FAIL watchdog: got cycle %0d, expected to reach %0d", cyc, END_CYC);
    $fatal(1, "watchdog expired");
  end

endmodule
